st_align_unit: RTL
==================

// Module: st_align_unit
// PURPOSE
//  Store-side counterpart of the load select path. Takes one store request (byte/half/word
//  plus byte address) and turns it into word-aligned data-memory write beats.
//  Each beat carries shifted data and a byte-write strobe. A store that crosses a word
//  boundary is split into two beats. Sits between the MEM stage and the data-memory write port.
// PARAMETERS
//  ADDR_WIDTH      32  byte-address width; mem_addr arithmetic wraps modulo 2^ADDR_WIDTH
//  CNT_WIDTH       16  width of split_cnt
//  ALLOW_MISALIGN  1   1: split boundary-crossing stores; 0: flag them as errors, issue no beat
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           asynchronous reset, active-low
//  req_valid   in   1           store request valid
//  req_ready   out  1           unit can accept a request (high only in IDLE)
//  req_addr    in   ADDR_WIDTH  byte address
//  req_data    in   32          store data, LSB-justified
//  req_size    in   3           0=byte, 1=half, 2=word, 3..7=illegal (same encoding as load sel)
//  mem_valid   out  1           write beat valid
//  mem_ready   in   1           memory accepts beat
//  mem_addr    out  ADDR_WIDTH  word-aligned address ([1:0]=0)
//  mem_wdata   out  32          shifted data; disabled byte lanes driven 0
//  mem_wstrb   out  4           byte-lane write enables
//  st_done     out  1           1-cycle pulse: request fully completed or rejected
//  st_err      out  1           qualifies st_done: request rejected, no beat issued
//  split_cnt   out  CNT_WIDTH   count of split stores, saturating at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - State goes to IDLE.
//   - All outputs 0 except req_ready=1; split_cnt=0.
//   - Reset mid-beat abandons the store; no st_done is produced.
//  FSM states: IDLE, BEAT0, BEAT1, ERR
//  IDLE
//   - req_ready=1. Accept on req_valid && req_ready.
//   - off=req_addr[1:0]; n=1/2/4 bytes for size 0/1/2.
//   - 64-bit lane image: D = {32'b0,req_data} << 8*off; M = ((1<<n)-1) << off (8 bits).
//   - Bytes of D outside M are forced to 0. Beat0 = D[31:0]/M[3:0]; beat1 = D[63:32]/M[7:4].
//   - split = (M[7:4] != 0).
//   - Go to ERR if size illegal, or if split && !ALLOW_MISALIGN. Otherwise go to BEAT0.
//   - Beat data and strobes are registered at accept. No combinational path from req_* to mem_*.
//  BEAT0
//   - mem_valid=1; mem_addr={req_addr[AW-1:2],2'b00}; beat0 data/strobe.
//   - On mem_ready: go to BEAT1 if split, else IDLE with st_done=1 (registered pulse).
//   - On a split, split_cnt increments when the store is accepted.
//  BEAT1
//   - mem_valid=1; mem_addr = beat0 address + 4 (wraps at top of address space).
//   - On mem_ready: go to IDLE with st_done=1.
//  ERR
//   - Lasts exactly one cycle: st_done=1, st_err=1, mem_valid=0. Then go to IDLE.
//  Handshake rules
//   - While mem_valid && !mem_ready, mem_addr/wdata/wstrb hold stable.
//   - mem_valid never drops before mem_ready.
//  Latency and throughput
//   - Accept at edge N gives mem_valid from cycle N+1.
//   - With mem_ready=1: 1 beat + done = 2 cycles from accept; split store = 3 cycles.
//   - st_done is asserted in the same cycle req_ready returns to 1; a new request may be
//     accepted in that cycle.
//  Other rules
//   - req_* is ignored outside IDLE.
//   - st_err=0 whenever st_done=0.
//   - split_cnt saturates at all-ones.
// TESTING
//  1 sb addr 0x1003 data 0xabcdef12, mem_ready=1
//    -> one beat: addr 0x1000, wdata 0x12000000, wstrb 4'b1000; st_done 1 cycle; split_cnt=0
//  2 sh addr 0x1001 data 0xabcdef12
//    -> addr 0x1000, wdata 0x00ef1200, wstrb 4'b0110; single beat
//  3 sw addr 0x1002 data 0xabcdef12
//    -> beat0: 0x1000 / 0xef120000 / 4'b1100; beat1: 0x1004 / 0x0000abcd / 4'b0011
//    -> split_cnt=1; st_done after beat1 only
//  4 sw addr 0x2000 with mem_ready low for 3 cycles
//    -> mem_valid=1, outputs stable at 0x2000 / 0xabcdef12 / 4'b1111; req_ready=0 throughout
//  5 req_size=3; then ALLOW_MISALIGN=0 with sh at 0x1003
//    -> no mem_valid; st_done=st_err=1 for one cycle; req_ready=1 next cycle
//  6 rst_n low during BEAT1 of test 3
//    -> immediately mem_valid=0, req_ready=1, split_cnt=0, no st_done; next sb works normally

Source files
------------

// File: rtl/st_align_unit.sv
// rtl/st_align_unit.sv - store alignment unit: turns byte/half/word stores into word-aligned write beats
module st_align_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [2:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  st_done,
  output logic                  st_err,
  output logic [CNT_WIDTH-1:0]  split_cnt
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ERR} state_t;

  state_t                state, state_nx;
  logic                  done_q, done_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data0_q, data1_q;
  logic [3:0]            strb0_q, strb1_q;
  logic                  split_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic [1:0]  off;
  logic [7:0]  mask;
  logic [63:0] img, img_m;
  logic        size_bad, split, accept;

  // Two-word lane image of the store; beat1 is only used when the mask spills into the upper word.
  always_comb begin
    off      = req_addr[1:0];
    size_bad = 1'b0;
    case (req_size)
      3'd0:    mask = 8'h01;
      3'd1:    mask = 8'h03;
      3'd2:    mask = 8'h0f;
      default: begin
        mask     = 8'h00;
        size_bad = 1'b1;
      end
    endcase
    mask  = mask << off;
    img   = {32'b0, req_data} << {off, 3'b000};
    img_m = '0;
    for (int i = 0; i < 8; i++) begin
      img_m[i*8 +: 8] = mask[i] ? img[i*8 +: 8] : 8'h00;
    end
    split  = |mask[7:4];
    accept = req_valid && (state == IDLE);
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = (size_bad || (split && !ALLOW_MISALIGN)) ? ERR : BEAT0;
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (split_q) begin
            state_nx = BEAT1;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data0_q <= '0;
      data1_q <= '0;
      strb0_q <= '0;
      strb1_q <= '0;
      split_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state  <= state_nx;
      done_q <= done_nx;
      if (accept) begin
        addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        data0_q <= img_m[31:0];
        data1_q <= img_m[63:32];
        strb0_q <= mask[3:0];
        strb1_q <= mask[7:4];
        split_q <= split;
        // Rejected stores never count as splits.
        if (split && (state_nx == BEAT0) && (cnt_q != '1)) begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    mem_valid = (state == BEAT0) || (state == BEAT1);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state == BEAT0) begin
      mem_addr  = addr_q;
      mem_wdata = data0_q;
      mem_wstrb = strb0_q;
    end else if (state == BEAT1) begin
      mem_addr  = addr_q + ADDR_WIDTH'(4);
      mem_wdata = data1_q;
      mem_wstrb = strb1_q;
    end
    st_done   = done_q || (state == ERR);
    st_err    = (state == ERR);
    split_cnt = cnt_q;
  end

endmodule
